// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 recoding in booth_step and halves the step count.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int MULT_WIDTH = 32;
  localparam int CNT_W      = $clog2(MULT_WIDTH);
  localparam int STEPS_R2   = MULT_WIDTH;
  localparam int STEPS_R4   = MULT_WIDTH / 2;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_POS1,
    BOOTH_NEG1,
    BOOTH_POS2,
    BOOTH_NEG2
  } booth_op_e;

  // Radix-2 recoding of {p_lo[0], q-1}
  function automatic booth_op_e booth_recode_r2(input logic [1:0] bits);
    case (bits)
      2'b01:   return BOOTH_POS1;
      2'b10:   return BOOTH_NEG1;
      default: return BOOTH_ZERO;
    endcase
  endfunction

  // Modified Booth recoding of {p_lo[1:0], q-1}
  function automatic booth_op_e booth_recode_r4(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return BOOTH_POS1;
      3'b011:         return BOOTH_POS2;
      3'b100:         return BOOTH_NEG2;
      3'b101, 3'b110: return BOOTH_NEG1;
      default:        return BOOTH_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: recode, add/sub into P_hi, arithmetic shift.
// Accumulator layout: {P_hi[WIDTH], P_lo[WIDTH], q-1}. Radix-4 when BOOTH_RADIX4_EN is defined.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] m,
  input  logic [2*WIDTH:0] acc_in,
  output logic [2*WIDTH:0] acc_out
);

`ifdef BOOTH_RADIX4_EN
  localparam int EW = WIDTH + 2;
`else
  localparam int EW = WIDTH + 1;
`endif

  // Extra headroom bits keep P_hi +/- M (or 2M) exact for M = -2^(WIDTH-1)
  logic signed [EW-1:0] p_ext, m_ext, sum;
  booth_op_e            op;

  assign p_ext = {{(EW-WIDTH){acc_in[2*WIDTH]}}, acc_in[2*WIDTH:WIDTH+1]};
  assign m_ext = {{(EW-WIDTH){m[WIDTH-1]}}, m};

`ifdef BOOTH_RADIX4_EN
  assign op = booth_recode_r4(acc_in[2:0]);
`else
  assign op = booth_recode_r2(acc_in[1:0]);
`endif

  always_comb begin
    sum = p_ext;
    case (op)
      BOOTH_POS1: sum = p_ext + m_ext;
      BOOTH_NEG1: sum = p_ext - m_ext;
      BOOTH_POS2: sum = p_ext + (m_ext <<< 1);
      BOOTH_NEG2: sum = p_ext - (m_ext <<< 1);
      default:    sum = p_ext;
    endcase
  end

  // Shifting {sum, P_lo, q-1} right drops the low bits; sum already carries the sign fill
`ifdef BOOTH_RADIX4_EN
  assign acc_out = {sum, acc_in[WIDTH:2]};
`else
  assign acc_out = {sum, acc_in[WIDTH:1]};
`endif

endmodule

// File: rtl/booth_mult.sv
// Sequential signed multiplier feeding Hi/Lo: IDLE -> RUN (one Booth step per edge) -> DONE.
// Define BOOTH_RADIX4_EN for radix-4 (WIDTH/2 steps, WIDTH must be even).
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

`ifdef BOOTH_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
`else
  localparam int STEPS = WIDTH;
`endif
  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(STEPS - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] m;
  logic [2*WIDTH:0] acc, acc_nxt;
  logic [CW-1:0]    cnt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .m      (m),
    .acc_in (acc),
    .acc_out(acc_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: if (start) begin
          m   <= a;
          acc <= {{WIDTH{1'b0}}, b, 1'b0};
          cnt <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          // Hi/Lo only change on the final step so they hold through the next run
          if (cnt == LAST) {hi, lo} <= acc_nxt[2*WIDTH:1];
        end
        default: ;
      endcase
    end
  end

endmodule
